// File: rtl/keyed_memory.sv
// Word memory with power-up initialisation and key-selected whole-array transform sweeps.
// Optional macro KEYED_MEM_STATUS_EN adds a saturating completed-sweep counter output.
module keyed_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_write,
    input  logic [15:0]       key_access_in,
    input  logic              key_load,
    output logic [DATA_W-1:0] read_data,
    output logic [15:0]       key_access_out,
    output logic              busy,
    output logic              sweep_done,
    output logic              key_error
`ifdef KEYED_MEM_STATUS_EN
    ,
    output logic [15:0]       sweep_count
`endif
);

    // state | meaning
    // INIT  | filling every word with INIT_VAL, one word per cycle
    // IDLE  | host reads/writes, keys accepted
    // SWEEP | read-modify-write of every word with the latched key transform
    typedef enum logic [1:0] {INIT, IDLE, SWEEP} state_t;

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [DATA_W-1:0] INIT_VAL = DATA_W'(8'hA8);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [ADDR_W:0]   idx_q;
    logic [DATA_W-1:0] read_data_q;
    logic [15:0]       key_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
`ifdef KEYED_MEM_STATUS_EN
    logic [15:0]       cnt_q;
`endif

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    function automatic logic key_valid(input logic [15:0] k);
        return (k == 16'h0032) || (k == 16'h0087) || (k == 16'h1024) || (k == 16'h0324);
    endfunction

    function automatic logic [DATA_W-1:0] xform(input logic [15:0] k, input logic [DATA_W-1:0] m);
        logic [DATA_W-1:0] t;
        t = m;
        case (k)
            16'h0032: t = ((m ^ DATA_W'(8'h02)) + DATA_W'(9)) * DATA_W'(3);
            16'h0087: t = ~(((m << 1) + DATA_W'(7)) ^ DATA_W'(8'h5A));
            16'h1024: t = ((m ^ DATA_W'(8'hA3)) + DATA_W'(17)) >> 1;
            16'h0324: t = ((m ^ DATA_W'(8'h3F)) + DATA_W'(21)) * DATA_W'(2);
            default:  t = m;
        endcase
        return t;
    endfunction

    // Single write port shared by init fill, sweep and host writes; reset blocks all writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = write_data;
        case (state_q)
            INIT: begin
                mem_we    = rst_n;
                mem_waddr = idx_q[ADDR_W-1:0];
                mem_wdata = INIT_VAL;
            end
            SWEEP: begin
                mem_we    = rst_n;
                mem_waddr = idx_q[ADDR_W-1:0];
                mem_wdata = xform(key_q, mem[idx_q[ADDR_W-1:0]]);
            end
            IDLE: begin
                mem_we = rst_n & mem_write;
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            idx_q       <= '0;
            read_data_q <= '0;
            key_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef KEYED_MEM_STATUS_EN
            cnt_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                INIT, SWEEP: begin
                    err_q <= key_load;
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef KEYED_MEM_STATUS_EN
                        if (state_q == SWEEP && cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (!mem_write) begin
                        read_data_q <= mem[address];
                    end
                    if (key_load) begin
                        if (key_valid(key_access_in)) begin
                            key_q   <= key_access_in;
                            state_q <= SWEEP;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= INIT;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign read_data      = read_data_q;
    assign key_access_out = key_q;
    assign busy           = busy_q;
    assign sweep_done     = done_q;
    assign key_error      = err_q;
`ifdef KEYED_MEM_STATUS_EN
    assign sweep_count    = cnt_q;
`endif

endmodule

// File: tb/tb_keyed_memory.sv
// Self-checking bench for keyed_memory (ADDR_W=4, DATA_W=32): whole-array reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_keyed_memory;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] write_data = '0;
    logic          mem_write = 1'b0;
    logic [15:0]   key_access_in = '0;
    logic          key_load = 1'b0;
    logic [DW-1:0] read_data;
    logic [15:0]   key_access_out;
    logic          busy;
    logic          sweep_done;
    logic          key_error;
`ifdef KEYED_MEM_STATUS_EN
    logic [15:0]   sweep_count;
`endif

    always #5 clk = ~clk;

    keyed_memory #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .address        (address),
        .write_data     (write_data),
        .mem_write      (mem_write),
        .key_access_in  (key_access_in),
        .key_load       (key_load),
        .read_data      (read_data),
        .key_access_out (key_access_out),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .key_error      (key_error)
`ifdef KEYED_MEM_STATUS_EN
        ,
        .sweep_count    (sweep_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: the array is transformed as a whole when a sweep finishes,
    // since no word is observable from outside while the block is busy.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left = 0;
    bit            m_init = 1'b1;
    logic [DW-1:0] e_rd = '0;
    logic [15:0]   e_key = '0;
    bit            e_done = 1'b0;
    bit            e_err = 1'b0;
    int            e_cnt = 0;
    bit            chk_en = 1'b0;

    function automatic logic [31:0] ref_xform(input logic [15:0] k, input logic [31:0] m);
        case (k)
            16'h0032: return ((m ^ 32'h02) + 32'd9) * 32'd3;
            16'h0087: return ~(((m << 1) + 32'd7) ^ 32'h5A);
            16'h1024: return ((m ^ 32'hA3) + 32'd17) >> 1;
            16'h0324: return ((m ^ 32'h3F) + 32'd21) * 32'd2;
            default:  return m;
        endcase
    endfunction

    function automatic bit ref_valid(input logic [15:0] k);
        return k inside {16'h0032, 16'h0087, 16'h1024, 16'h0324};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = DEPTH; m_init = 1'b1; e_rd = '0; e_key = '0;
            e_done = 1'b0; e_err = 1'b0; e_cnt = 0; chk_en = 1'b1;
        end else if (chk_en) begin
            e_done = 1'b0;
            e_err  = 1'b0;
            if (m_left > 0) begin
                e_err = key_load;
                m_left--;
                if (m_left == 0) begin
                    e_done = 1'b1;
                    for (int i = 0; i < DEPTH; i++)
                        m_mem[i] = m_init ? 32'h0000_00A8 : ref_xform(e_key, m_mem[i]);
                    if (!m_init && e_cnt < 65535) e_cnt++;
                end
            end else begin
                if (mem_write) m_mem[address] = write_data;
                else           e_rd = m_mem[address];
                if (key_load) begin
                    if (ref_valid(key_access_in)) begin
                        e_key = key_access_in; m_left = DEPTH; m_init = 1'b0;
                    end else begin
                        e_err = 1'b1;
                    end
                end
            end
        end
        #1;
        if (chk_en) begin
            check("cyc_read_data", read_data, e_rd);
            check("cyc_key_out", key_access_out, e_key);
            check("cyc_busy", busy, m_left > 0);
            check("cyc_sweep_done", sweep_done, e_done);
            check("cyc_key_error", key_error, e_err);
`ifdef KEYED_MEM_STATUS_EN
            check("cyc_sweep_count", sweep_count, 16'(e_cnt));
`endif
        end
    end

    // All driver tasks are entered and left at a falling edge.
    task automatic idle_inputs();
        address = '0; write_data = '0; mem_write = 1'b0; key_load = 1'b0; key_access_in = '0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle_inputs();
        repeat (n) @(negedge clk);
        check("rst_busy", busy, 1'b1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_key_out", key_access_out, 16'h0);
        check("rst_done_err", {sweep_done, key_error}, 2'b00);
        rst_n = 1'b1;
    endtask

    task automatic wait_sweep(output int bc, output int dc);
        bit finished = 1'b0;
        bc = 0; dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (sweep_done) dc++;
            if (!busy) begin finished = 1'b1; break; end
            bc++;
            @(negedge clk);
        end
        check("sweep_timeout", !finished, 1'b0);
    endtask

    task automatic do_key(input logic [15:0] k);
        key_access_in = k; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0; key_access_in = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        address = a; write_data = d; mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        address = a; mem_write = 1'b0;
        @(negedge clk);
        d = read_data;
    endtask

    task automatic check_all(input string name, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i), d);
            if (d !== exp) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        int bc, dc, r;
        logic [DW-1:0] d;
        logic [15:0] codes [4];
        codes[0] = 16'h0032; codes[1] = 16'h0087; codes[2] = 16'h1024; codes[3] = 16'h0324;

        @(negedge clk);
        do_reset(3);
        wait_sweep(bc, dc);
        check("init_busy_cycles", bc, 16);
        check("init_done_pulses", dc, 1);
        do_read(4'd3, d);
        check("init_read3", d, 32'h0000_00A8);
        check("model_init3", m_mem[3], 32'h0000_00A8);

        do_key(16'h0032);
        wait_sweep(bc, dc);
        check("k32_busy_cycles", bc, 16);
        check("k32_done_pulses", dc, 1);
        check("k32_key_out", key_access_out, 16'h0032);
        check_all("k32_all_words", 32'h0000_0219);
        check("model_k32", m_mem[9], 32'h0000_0219);

        do_write(4'd5, 32'h0);
        do_key(16'h0087);
        wait_sweep(bc, dc);
        do_read(4'd5, d);
        check("k87_addr5", d, 32'hFFFF_FFA2);

        do_reset(2);
        wait_sweep(bc, dc);
        do_key(16'h1024);
        wait_sweep(bc, dc);
        check_all("k1024_all_words", 32'h0000_000E);

        do_key(16'h1234);
        check("badkey_error", key_error, 1'b1);
        check("badkey_busy", busy, 1'b0);
        @(negedge clk);
        check("badkey_error_pulse", key_error, 1'b0);
        check("badkey_key_out", key_access_out, 16'h1024);
        do_read(4'd0, d);
        check("badkey_mem", d, 32'h0000_000E);

        do_key(16'h0324);
        repeat (3) @(negedge clk);
        key_access_in = 16'h0324; key_load = 1'b1;
        address = 4'd2; write_data = 32'hDEAD_BEEF; mem_write = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("busykey_error", key_error, 1'b1);
        check("busykey_busy", busy, 1'b1);
        wait_sweep(bc, dc);
        check("k324_done_pulses", dc, 1);
        check("k324_key_out", key_access_out, 16'h0324);
        do_read(4'd2, d);
        check("k324_addr2", d, 32'h0000_008C);

        do_key(16'h0032);
        repeat (7) @(negedge clk);
        do_reset(1);
        wait_sweep(bc, dc);
        check("abort_init_cycles", bc, 16);
        check_all("abort_all_words", 32'h0000_00A8);

`ifdef KEYED_MEM_STATUS_EN
        for (int k = 0; k < 3; k++) begin
            do_key(codes[k]);
            wait_sweep(bc, dc);
        end
        check("status_count3", sweep_count, 16'd3);
        do_reset(1);
        check("status_count_rst", sweep_count, 16'd0);
        wait_sweep(bc, dc);
`endif

        for (int c = 0; c < 2000; c++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            address       = AW'($urandom);
            write_data    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            mem_write     = 1'($urandom_range(0, 1));
            key_load      = ($urandom_range(0, 14) == 0);
            r             = $urandom_range(0, 5);
            key_access_in = (r < 4) ? codes[r] : 16'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        idle_inputs();
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
